// File: rtl/str_frame_packer.sv
// Packs a framed sample stream into 32-bit AXI-Stream frames: SYNC header, sign-extended
// samples, then a trailer {seq, bad_len, count}. Framing is enforced locally by a sample counter.
module str_frame_packer #(
   parameter int          DW        = 24,
   parameter int          FRAME_LEN = 16000,
   parameter logic [31:0] SYNC      = 32'hA5A5_5A5A
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [DW-1:0] s_axis_tdata,
   input  logic          s_axis_tlast,
   input  logic          s_axis_tvalid,
   output logic          s_axis_tready,
   output logic [31:0]   m_axis_tdata,
   output logic          m_axis_tlast,
   output logic          m_axis_tvalid,
   input  logic          m_axis_tready,
   output logic [15:0]   frame_seq,
   output logic          frame_err
);

   typedef enum logic [1:0] {
      ST_HDR  = 2'd0,
      ST_DATA = 2'd1,
      ST_TRL  = 2'd2
   } state_t;

   localparam logic [15:0] FRAME_LEN_W = 16'(FRAME_LEN);

   state_t      state_reg;
   logic [15:0] seq_reg;
   logic [15:0] count_reg;
   logic [15:0] count_next;
   logic        bad_len_reg;
   logic        bad_len_next;
   logic        frame_full;
   logic        frame_close;
   logic        can_load;
   logic [31:0] m_data_reg;
   logic        m_last_reg;
   logic        m_valid_reg;
   logic        frame_err_reg;
   logic [31:0] sample_ext;

   // Per-bit sign extension also covers DW=32, where no replication bits exist.
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_ext
         if (gi < DW) begin : g_data
            assign sample_ext[gi] = s_axis_tdata[gi];
         end else begin : g_sign
            assign sample_ext[gi] = s_axis_tdata[DW-1];
         end
      end
   endgenerate

   // Output register can take a new word when empty or when its word leaves this cycle.
   assign can_load     = !m_valid_reg || m_axis_tready;
   assign count_next   = count_reg + 16'd1;
   assign frame_full   = (count_next == FRAME_LEN_W);
   assign frame_close  = s_axis_tlast || frame_full;
   assign bad_len_next = s_axis_tlast ^ frame_full;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg     <= ST_HDR;
         seq_reg       <= 16'd0;
         count_reg     <= 16'd0;
         bad_len_reg   <= 1'b0;
         m_data_reg    <= 32'd0;
         m_last_reg    <= 1'b0;
         m_valid_reg   <= 1'b0;
         frame_err_reg <= 1'b0;
      end else begin
         frame_err_reg <= m_valid_reg && m_axis_tready && m_last_reg && m_data_reg[15];
         if (m_valid_reg && m_axis_tready) begin
            m_valid_reg <= 1'b0;
         end
         case (state_reg)
            ST_HDR: begin
               // A header is only emitted once a sample is actually waiting.
               if (s_axis_tvalid && can_load) begin
                  m_data_reg  <= SYNC;
                  m_last_reg  <= 1'b0;
                  m_valid_reg <= 1'b1;
                  state_reg   <= ST_DATA;
               end
            end
            ST_DATA: begin
               if (s_axis_tvalid && can_load) begin
                  m_data_reg  <= sample_ext;
                  m_last_reg  <= 1'b0;
                  m_valid_reg <= 1'b1;
                  count_reg   <= count_next;
                  if (frame_close) begin
                     bad_len_reg <= bad_len_next;
                     state_reg   <= ST_TRL;
                  end
               end
            end
            ST_TRL: begin
               if (can_load) begin
                  m_data_reg  <= {seq_reg, bad_len_reg, count_reg[14:0]};
                  m_last_reg  <= 1'b1;
                  m_valid_reg <= 1'b1;
                  seq_reg     <= seq_reg + 16'd1;
                  count_reg   <= 16'd0;
                  state_reg   <= ST_HDR;
               end
            end
            default: begin
               state_reg <= ST_HDR;
            end
         endcase
      end
   end

   assign s_axis_tready = (state_reg == ST_DATA) && can_load && !rst;
   assign m_axis_tdata  = m_data_reg;
   assign m_axis_tlast  = m_last_reg;
   assign m_axis_tvalid = m_valid_reg;
   assign frame_seq     = seq_reg;
   assign frame_err     = frame_err_reg;

endmodule

// File: tb/tb_str_frame_packer.sv
// Scoreboard bench for str_frame_packer (FRAME_LEN=4): a framing model queues the expected
// words as samples are offered, a negedge monitor pops and compares transferred words.
module tb_str_frame_packer;

   localparam int          DW   = 24;
   localparam int          FL   = 4;
   localparam logic [31:0] SYNC = 32'hA5A5_5A5A;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [DW-1:0] s_tdata = '0;
   logic          s_tlast = 1'b0;
   logic          s_tvalid = 1'b0;
   logic          s_tready;
   logic [31:0]   m_tdata;
   logic          m_tlast;
   logic          m_tvalid;
   logic          m_tready = 1'b1;
   logic [15:0]   frame_seq;
   logic          frame_err;

   int checks = 0;
   int errors = 0;

   // expected word = {last, data}
   logic [32:0] exp_q[$];
   logic [15:0] mdl_seq = 16'd0;
   int          mdl_cnt = 0;
   bit          mdl_in_frame = 1'b0;
   bit          rand_ready = 1'b0;
   bit          err_exp = 1'b0;
   bit          prev_stall = 1'b0;
   logic [31:0] prev_data = '0;
   logic        prev_last = 1'b0;

   always #5 clk = ~clk;

   str_frame_packer #(.DW(DW), .FRAME_LEN(FL), .SYNC(SYNC)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_tdata),
      .s_axis_tlast  (s_tlast),
      .s_axis_tvalid (s_tvalid),
      .s_axis_tready (s_tready),
      .m_axis_tdata  (m_tdata),
      .m_axis_tlast  (m_tlast),
      .m_axis_tvalid (m_tvalid),
      .m_axis_tready (m_tready),
      .frame_seq     (frame_seq),
      .frame_err     (frame_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_push(input logic [DW-1:0] d, input logic l);
      logic signed [DW-1:0] sd;
      logic signed [31:0]   ext;
      bit                   bad;
      sd  = d;
      ext = sd;
      if (!mdl_in_frame) begin
         exp_q.push_back({1'b0, SYNC});
         mdl_in_frame = 1'b1;
      end
      exp_q.push_back({1'b0, ext});
      mdl_cnt++;
      if (l || mdl_cnt == FL) begin
         bad = l ? (mdl_cnt != FL) : 1'b1;
         exp_q.push_back({1'b1, mdl_seq, bad, 15'(mdl_cnt)});
         mdl_seq      = mdl_seq + 16'd1;
         mdl_cnt      = 0;
         mdl_in_frame = 1'b0;
      end
   endtask

   task automatic send(input logic [DW-1:0] d, input logic l);
      bit acc;
      int n;
      model_push(d, l);
      s_tdata  = d;
      s_tlast  = l;
      s_tvalid = 1'b1;
      acc = 1'b0;
      n   = 0;
      while (!acc) begin
         @(negedge clk);
         if (s_tready) acc = 1'b1;
         @(posedge clk);
         #1;
         n++;
         if (!acc && n > 1000) begin
            check("send_timeout", 32'(acc), 32'd1);
            break;
         end
      end
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || m_tvalid) && n < 2000) begin
         @(negedge clk);
         n++;
      end
      check("drain_done", 32'(exp_q.size()), 32'd0);
      repeat (3) @(negedge clk);
   endtask

   // Downstream ready driver
   initial begin
      forever begin
         @(posedge clk);
         #1;
         m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   // Output monitor
   initial begin
      logic [32:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 1'b0;
            err_exp    = 1'b0;
         end else begin
            check("frame_err", 32'(frame_err), 32'(err_exp));
            err_exp = 1'b0;
            if (prev_stall) begin
               check("stall_valid", 32'(m_tvalid), 32'd1);
               check("stall_data", m_tdata, prev_data);
               check("stall_last", 32'(m_tlast), 32'(prev_last));
            end
            if (m_tvalid && m_tready) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_word", m_tdata, 32'hxxxx_xxxx);
               end else begin
                  e = exp_q.pop_front();
                  $display("txn data=%h last=%b exp=%h", m_tdata, m_tlast, e[31:0]);
                  check("word_data", m_tdata, e[31:0]);
                  check("word_last", 32'(m_tlast), 32'(e[32]));
                  err_exp = e[32] && e[15];
               end
            end
            prev_stall = m_tvalid && !m_tready;
            prev_data  = m_tdata;
            prev_last  = m_tlast;
         end
      end
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_m_valid", 32'(m_tvalid), 32'd0);
      check("rst_m_data", m_tdata, 32'd0);
      check("rst_m_last", 32'(m_tlast), 32'd0);
      check("rst_s_ready", 32'(s_tready), 32'd0);
      check("rst_seq", 32'(frame_seq), 32'd0);
      check("rst_err", 32'(frame_err), 32'd0);
      repeat (3) @(negedge clk);
      check("idle_no_hdr", 32'(m_tvalid), 32'd0);
      @(posedge clk);
      #1;

      // T1: basic frame
      send(24'hFFFFFF, 1'b0);
      send(24'h000002, 1'b0);
      send(24'hFFFFFD, 1'b0);
      send(24'h000004, 1'b1);
      drain();
      check("t1_seq", 32'(frame_seq), 32'(mdl_seq));

      // T2: two back-to-back frames
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < FL; i++)
            send(24'(f * 16 + i), (i == FL - 1));
      drain();
      check("t2_seq", 32'(frame_seq), 32'(mdl_seq));

      // T3: early tlast, then a clean frame
      send(24'h800000, 1'b0);
      send(24'h7FFFFF, 1'b1);
      for (int i = 0; i < FL; i++) send(24'(100 + i), (i == FL - 1));
      drain();

      // T4: missing tlast, counter closes the frame
      for (int i = 0; i < 8; i++) send(24'(200 + i), (i == 7));
      drain();
      check("t4_seq", 32'(frame_seq), 32'(mdl_seq));

      // T5: random backpressure over 3 frames
      rand_ready = 1'b1;
      for (int f = 0; f < 3; f++)
         for (int i = 0; i < FL; i++)
            send(24'($urandom), (i == FL - 1));
      rand_ready = 1'b0;
      drain();
      check("t5_seq", 32'(frame_seq), 32'(mdl_seq));

      // T6: reset mid-frame
      send(24'h000011, 1'b0);
      send(24'h000022, 1'b0);
      rst = 1'b1;
      exp_q.delete();
      mdl_seq      = 16'd0;
      mdl_cnt      = 0;
      mdl_in_frame = 1'b0;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_valid_after_rst", 32'(m_tvalid), 32'd0);
      check("t6_seq_after_rst", 32'(frame_seq), 32'd0);
      @(posedge clk);
      #1;
      for (int i = 0; i < FL; i++) send(24'(300 + i), (i == FL - 1));
      drain();
      check("t6_seq", 32'(frame_seq), 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
